video_scandoubler: RTL and testbench
====================================

// Module: video_scandoubler
// PURPOSE
//  Downstream of the PPU. Captures the 6-bit palette index the PPU emits once per ce
//  into a ping-pong pair of 256-entry line buffers. Replays each source line twice at
//  2x pixel rate, producing 512x480 active video with hsync/vsync/de.
//  Converts indices to 24-bit RGB through a fixed 64-entry 2C02 palette ROM.
// PARAMETERS
//  PIX_DELAY  1    ce cycles between PPU cycle value and matching color; write x = cycle - PIX_DELAY
//  H_ACTIVE   512  active pixels per output line
//  H_FP       14   front porch (pix_ce)
//  H_SYNC     64   sync width (pix_ce)
//  H_TOTAL    682  pix_ce per output line; 2*H_TOTAL must equal 341*4 clk
//  V_ACTIVE   480  active output lines
//  V_FP       4    front porch lines
//  V_SYNC     4    vsync width (lines)
//  V_TOTAL    524  output lines per frame (262*2)
//  SYNC_POL   0    level of hsync/vsync while asserted
// PORTS
//  clk        in   1   system clock (21.48 MHz)
//  reset      in   1   synchronous, active-low reset
//  ce         in   1   PPU pixel enable (1 in 4 clk)
//  pix_ce     in   1   output pixel enable; tied high in default config
//  color      in   6   PPU palette index for current pixel
//  scanline   in   9   PPU scanline
//  cycle      in   9   PPU cycle within line
//  hsync      out  1   horizontal sync
//  vsync      out  1   vertical sync
//  de         out  1   data enable, high during active pixels
//  r, g, b    out  8   pixel colour (each 8 bits)
//  locked     out  1   output timing aligned to PPU frame
// BEHAVIOUR
//  Reset (reset==0 at posedge clk): hcnt=vcnt=0, locked=0, de=0, r=g=b=0,
//   hsync=vsync=!SYNC_POL, pipeline flushed; line-buffer contents undefined.
//  Write side: on ce with scanline<240 and 0<=cycle-PIX_DELAY<=255, write color to
//   buf[scanline[0]][(cycle-PIX_DELAY)[7:0]]. No writes for scanline>=240 (incl. 261)
//   or cycles 256..340.
//  Lock: on ce with scanline==1 and cycle==0: hcnt<=0, vcnt<=0, locked<=1, regardless
//   of the current count (resync every frame). Takes precedence over pix_ce advance.
//  Counters: on pix_ce, hcnt++; at H_TOTAL-1 wraps to 0 and vcnt++ (wrap at V_TOTAL-1).
//  Source mapping: src_line=vcnt[8:1], src_x=hcnt[8:1]; read buf[src_line[0]].
//   Output line pair shows PPU line n while PPU writes line n+1 into other buffer.
//  Timing (raw, pre-pipeline): active = hcnt<H_ACTIVE && vcnt<V_ACTIVE && locked;
//   hsync asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC;
//   vsync asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
//  Pipeline: stage1 registered line-buffer read, stage2 registered palette ROM read;
//   hsync/vsync/de delayed by the same 2 pix_ce so all outputs align. Pipeline
//   advances only on pix_ce.
//  RGB outputs forced to 0 whenever de==0.
//  Palette: 64x24 ROM holding standard 2C02 NTSC table; $0F=000000, $30=FFFFFF;
//   $0D/$1D treated as black.
//  Lock loss: none once locked; only reset clears locked. Before lock, syncs still run
//   free from reset so a monitor sees stable timing; de stays 0.
//  Reset mid-frame: counters and pipeline cleared immediately; de low until next lock.
//  Simultaneous ce-write and pix_ce-read to the same buffer: dual-port RAM; read
//   returns old data (never occurs with locked timing).
// TESTING
//  1 PPU model writes color=x[5:0] on line 0, lock -> output lines 0 and 1 show
//    pixels 2x,2x+1 = palette(x); de high exactly 512 pix_ce per line.
//  2 Line 0 all $30, line 1 all $0F -> out lines 0-1 rgb FFFFFF, lines 2-3 000000.
//  3 Free run after lock -> hsync width 64, period 682; vsync 4 lines at vcnt 484..487
//    (+2 pix_ce pipeline); period 524 lines.
//  4 Assert reset at vcnt=200 for 1 clk -> next clk de=0, rgb=0, locked=0; relocks at
//    next scanline1/cycle0 event.
//  5 Drive color=$21 on scanline 240..261 and cycles 256..340 -> buffer contents and
//    displayed lines unchanged.
//  6 Force hcnt off by 37 before lock event -> after event hcnt=vcnt=0; alignment
//    restored within one frame.

Source files
------------

// File: rtl/video_scandoubler.sv
// Scan doubler: captures PPU palette indices into ping-pong line buffers and
// replays each source line twice at 2x rate as 512x480 RGB with hsync/vsync/de.
//
// Ports:
//   clk, reset (sync, active-low)   system clock and reset
//   ce, color, scanline, cycle      PPU pixel strobe, palette index and position
//   pix_ce                          output pixel enable
//   hsync, vsync, de, r, g, b       output video timing and colour
//   locked                          output timing aligned to the PPU frame
module video_scandoubler #(
    parameter int PIX_DELAY = 1,
    parameter int H_ACTIVE  = 512,
    parameter int H_FP      = 14,
    parameter int H_SYNC    = 64,
    parameter int H_TOTAL   = 682,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 4,
    parameter int V_TOTAL   = 524,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       pix_ce,
    input  logic [5:0] color,
    input  logic [8:0] scanline,
    input  logic [8:0] cycle,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       locked
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [8:0] PD     = 9'(PIX_DELAY);

    // Two 256-entry banks, selected by the source line's LSB.
    logic [5:0] line_buf [0:511];

    logic [8:0] wr_x;
    logic       wr_en;
    logic       lock_evt;

    logic [9:0] hcnt;
    logic [9:0] vcnt;

    logic       act_raw;
    logic       hs_raw;
    logic       vs_raw;

    logic [5:0] idx1;
    logic       de1;
    logic       hs1;
    logic       vs1;

    // cycle < PIX_DELAY wraps wr_x above 255, so one range test covers both ends.
    assign wr_x     = cycle - PD;
    assign wr_en    = ce && (scanline < 9'd240) && (cycle >= PD) && !wr_x[8];
    assign lock_evt = ce && (scanline == 9'd1) && (cycle == 9'd0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[{scanline[0], wr_x[7:0]}] <= color;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt   <= '0;
            vcnt   <= '0;
            locked <= 1'b0;
        end else if (lock_evt) begin
            hcnt   <= '0;
            vcnt   <= '0;
            locked <= 1'b1;
        end else if (pix_ce) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    assign act_raw = (hcnt < H_ACT) && (vcnt < V_ACT) && locked;
    assign hs_raw  = ((hcnt >= HS_BEG) && (hcnt < HS_END)) ? SYNC_POL : !SYNC_POL;
    assign vs_raw  = ((vcnt >= VS_BEG) && (vcnt < VS_END)) ? SYNC_POL : !SYNC_POL;

    function automatic logic [23:0] pal(input logic [5:0] i);
        case (i)
            6'h00: pal = 24'h7C7C7C;  6'h01: pal = 24'h0000FC;
            6'h02: pal = 24'h0000BC;  6'h03: pal = 24'h4428BC;
            6'h04: pal = 24'h940084;  6'h05: pal = 24'hA80020;
            6'h06: pal = 24'hA81000;  6'h07: pal = 24'h881400;
            6'h08: pal = 24'h503000;  6'h09: pal = 24'h007800;
            6'h0A: pal = 24'h006800;  6'h0B: pal = 24'h005800;
            6'h0C: pal = 24'h004058;
            6'h10: pal = 24'hBCBCBC;  6'h11: pal = 24'h0078F8;
            6'h12: pal = 24'h0058F8;  6'h13: pal = 24'h6844FC;
            6'h14: pal = 24'hD800CC;  6'h15: pal = 24'hE40058;
            6'h16: pal = 24'hF83800;  6'h17: pal = 24'hE45C10;
            6'h18: pal = 24'hAC7C00;  6'h19: pal = 24'h00B800;
            6'h1A: pal = 24'h00A800;  6'h1B: pal = 24'h00A844;
            6'h1C: pal = 24'h008888;
            6'h20: pal = 24'hF8F8F8;  6'h21: pal = 24'h3CBCFC;
            6'h22: pal = 24'h6888FC;  6'h23: pal = 24'h9878F8;
            6'h24: pal = 24'hF878F8;  6'h25: pal = 24'hF85898;
            6'h26: pal = 24'hF87858;  6'h27: pal = 24'hFCA044;
            6'h28: pal = 24'hF8B800;  6'h29: pal = 24'hB8F818;
            6'h2A: pal = 24'h58D854;  6'h2B: pal = 24'h58F898;
            6'h2C: pal = 24'h00E8D8;  6'h2D: pal = 24'h787878;
            6'h30: pal = 24'hFFFFFF;  6'h31: pal = 24'hA4E4FC;
            6'h32: pal = 24'hB8B8F8;  6'h33: pal = 24'hD8B8F8;
            6'h34: pal = 24'hF8B8F8;  6'h35: pal = 24'hF8A4C0;
            6'h36: pal = 24'hF0D0B0;  6'h37: pal = 24'hFCE0A8;
            6'h38: pal = 24'hF8D878;  6'h39: pal = 24'hD8F878;
            6'h3A: pal = 24'hB8F8B8;  6'h3B: pal = 24'hB8F8D8;
            6'h3C: pal = 24'h00FCFC;  6'h3D: pal = 24'hF8D8F8;
            // $0D/$1D and the unused $xE/$xF columns are black.
            default: pal = 24'h000000;
        endcase
    endfunction

    // Two-stage pipeline: buffer read, then palette lookup; timing rides along.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx1  <= '0;
            de1   <= 1'b0;
            hs1   <= !SYNC_POL;
            vs1   <= !SYNC_POL;
            de    <= 1'b0;
            hsync <= !SYNC_POL;
            vsync <= !SYNC_POL;
            r     <= '0;
            g     <= '0;
            b     <= '0;
        end else if (pix_ce) begin
            idx1  <= line_buf[{vcnt[1], hcnt[8:1]}];
            de1   <= act_raw;
            hs1   <= hs_raw;
            vs1   <= vs_raw;
            de    <= de1;
            hsync <= hs1;
            vsync <= vs1;
            {r, g, b} <= de1 ? pal(idx1) : 24'h000000;
        end
    end

endmodule

// File: tb/tb_video_scandoubler.sv
// Scoreboard bench for video_scandoubler: a PPU model writes directed lines,
// expected pixels are queued at issue and a negedge monitor pops and compares.
module tb_video_scandoubler;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       pix_ce;
    logic [5:0] color;
    logic [8:0] scanline;
    logic [8:0] cycle;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       locked;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int run    = 0;
    bit mon_en = 1'b0;
    logic [23:0] q[$];

    video_scandoubler dut (
        .clk(clk), .reset(reset), .ce(ce), .pix_ce(pix_ce),
        .color(color), .scanline(scanline), .cycle(cycle),
        .hsync(hsync), .vsync(vsync), .de(de),
        .r(r), .g(g), .b(b), .locked(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Directed pattern for line mode 0 and its hand-looked-up RGB values.
    function automatic logic [5:0] pat(input int x);
        case (x % 8)
            0: pat = 6'h00;  1: pat = 6'h0F;  2: pat = 6'h30;  3: pat = 6'h21;
            4: pat = 6'h16;  5: pat = 6'h2A;  6: pat = 6'h0D;  default: pat = 6'h1D;
        endcase
    endfunction

    function automatic logic [23:0] pat_rgb(input int x);
        case (x % 8)
            0: pat_rgb = 24'h7C7C7C;  1: pat_rgb = 24'h000000;
            2: pat_rgb = 24'hFFFFFF;  3: pat_rgb = 24'h3CBCFC;
            4: pat_rgb = 24'hF83800;  5: pat_rgb = 24'h58D854;
            default: pat_rgb = 24'h000000;
        endcase
    endfunction

    // mode 0 pattern, 1 all $0F, 2 all $30, 3 all $16, 4 all $21
    function automatic logic [5:0] pix_of(input int mode, input int c);
        if (c < 1 || c > 256) return 6'h21;
        case (mode)
            0: return pat(c - 1);
            1: return 6'h0F;
            2: return 6'h30;
            3: return 6'h16;
            default: return 6'h21;
        endcase
    endfunction

    function automatic logic [23:0] rgb_of(input int mode, input int x);
        case (mode)
            0: return pat_rgb(x);
            1: return 24'h000000;
            2: return 24'hFFFFFF;
            3: return 24'hF83800;
            default: return 24'h3CBCFC;
        endcase
    endfunction

    task automatic push_pair(input int mode);
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < 512; h++)
                q.push_back(rgb_of(mode, h / 2));
    endtask

    task automatic ppu_line(input int sl, input int mode);
        for (int c = 0; c < 341; c++) begin
            scanline = 9'(sl);
            cycle    = 9'(c);
            color    = pix_of(mode, c);
            ce       = 1'b1;
            @(posedge clk); #1;
            ce = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (de === 1'b1) begin
                run++;
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL pix_unexpected: got %0h want none", {r, g, b});
                end else begin
                    chk("pixel", {8'h0, r, g, b}, {8'h0, q.pop_front()});
                end
            end else begin
                chk("rgb_blank", {8'h0, r, g, b}, 32'h0);
                if (run != 0) begin
                    if (locked) chk("de_run", run, 512);
                    run = 0;
                end
            end
        end
    end

    int rcyc;
    int f1;
    int l2;
    bit got;

    initial begin
        reset = 1'b0; ce = 1'b0; pix_ce = 1'b1;
        color = '0; scanline = '0; cycle = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_de", de, 0);
        chk("rst_rgb", {r, g, b}, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_locked", locked, 0);
        mon_en = 1'b1;
        reset  = 1'b1;

        push_pair(0); ppu_line(0, 0);
        chk("locked_pre", locked, 0);
        push_pair(1); ppu_line(1, 1);
        chk("locked_post", locked, 1);
        push_pair(2); ppu_line(2, 2);
        push_pair(3); ppu_line(3, 3);
        push_pair(2); ppu_line(240, 4);
        push_pair(3); ppu_line(241, 4);
        ppu_line(242, 4);

        // Reset lands 98 pixels into output line 12 (bank 0 = white).
        for (int i = 0; i < 98; i++) q.push_back(24'hFFFFFF);
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rcyc = cyc;
        chk("mid_de", de, 0);
        chk("mid_rgb", {r, g, b}, 0);
        chk("mid_locked", locked, 0);
        chk("mid_hsync", hsync, 1);
        reset = 1'b1;
        chk("q_after_reset", q.size(), 0);

        got = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (hsync === 1'b0) begin got = 1; break; end
        end
        chk("hs_found", got, 1);
        chk("hs_first", cyc - rcyc, 528);
        f1 = cyc;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (hsync === 1'b1) break;
        end
        chk("hs_width", cyc - f1, 64);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (hsync === 1'b0) break;
        end
        chk("hs_period", cyc - f1, 682);
        chk("vs_idle", vsync, 1);
        chk("de_prelock", de, 0);

        // Relock at an arbitrary phase of the free-running counters.
        repeat (300) @(posedge clk);
        #1;
        push_pair(2);
        l2 = cyc + 1;
        fork
            ppu_line(1, 1);
            begin
                got = 0;
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (hsync === 1'b0) begin got = 1; break; end
                end
                chk("relock_hs_found", got, 1);
                chk("relock_hs", cyc - l2, 528);
            end
        join
        chk("relock_locked", locked, 1);
        chk("q_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
